// File: rtl/accum_window_walker_pkg.sv
// Codebase-wide configuration constants shared by the TileAccumUnit blocks.
package TauCfg;
   localparam int unsigned WORK_BW = 16;
   localparam int unsigned VDIM    = 2;
endpackage

// File: rtl/accum_window_walker_counter.sv
// N-dimensional row-major window counter: holds the current coordinate and
// advances it with per-dimension wrap and carry. Stride port under ACCUM_WALKER_STRIDE_EN.
module nd_window_counter #(
   parameter int unsigned BW  = TauCfg::WORK_BW,
   parameter int unsigned DIM = TauCfg::VDIM
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_load,
   input  logic [DIM-1:0][BW-1:0] i_load_val,
   input  logic                   i_adv,
   input  logic [DIM-1:0][BW-1:0] i_beg,
   input  logic [DIM-1:0][BW-1:0] i_end,
`ifdef ACCUM_WALKER_STRIDE_EN
   input  logic [DIM-1:0][BW-1:0] i_step,
`endif
   output logic [DIM-1:0][BW-1:0] o_coord,
   output logic                   o_wrap_all
);

   logic [DIM-1:0][BW-1:0] coord_q, coord_d;
   logic [DIM-1:0][BW:0]   nxt;
   logic [DIM-1:0]         wrap;
   logic [DIM-1:0]         carry;

   always_comb begin
      nxt     = '0;
      wrap    = '0;
      carry   = '0;
      coord_d = coord_q;
      for (int unsigned d = 0; d < DIM; d++) begin
`ifdef ACCUM_WALKER_STRIDE_EN
         nxt[d] = {1'b0, coord_q[d]} + {1'b0, i_step[d]};
`else
         nxt[d] = {1'b0, coord_q[d]} + {{BW{1'b0}}, 1'b1};
`endif
         // BW+1 bit compare so a carry-out past 2^BW also counts as a wrap
         wrap[d] = (nxt[d] >= {1'b0, i_end[d]});
      end
      carry[DIM-1] = 1'b1;
      for (int unsigned d = DIM-1; d > 0; d--) begin
         carry[d-1] = carry[d] & wrap[d];
      end
      if (i_load) begin
         coord_d = i_load_val;
      end else if (i_adv) begin
         for (int unsigned d = 0; d < DIM; d++) begin
            if (carry[d]) begin
               coord_d[d] = wrap[d] ? i_beg[d] : nxt[d][BW-1:0];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         coord_q <= '0;
      end else begin
         coord_q <= coord_d;
      end
   end

   assign o_coord    = coord_q;
   assign o_wrap_all = &wrap;

endmodule

// File: rtl/accum_window_walker.sv
// Accepts block descriptors and walks each accumulation window point by point.
// Optional per-dimension stride port enabled by ACCUM_WALKER_STRIDE_EN.
module accum_window_walker #(
   parameter int unsigned BW  = TauCfg::WORK_BW,
   parameter int unsigned DIM = TauCfg::VDIM
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   src_rdy,
   output logic                   src_ack,
   input  logic [DIM-1:0][BW-1:0] i_bofs,
   input  logic [DIM-1:0][BW-1:0] i_aofs_beg,
   input  logic [DIM-1:0][BW-1:0] i_aofs_end,
`ifdef ACCUM_WALKER_STRIDE_EN
   input  logic [DIM-1:0][BW-1:0] i_astep,
`endif
   input  logic                   i_islast,
   output logic                   dst_rdy,
   input  logic                   dst_ack,
   output logic [DIM-1:0][BW-1:0] o_bofs,
   output logic [DIM-1:0][BW-1:0] o_aofs,
   output logic [DIM-1:0][BW-1:0] o_pos,
   output logic                   o_lastpt,
   output logic                   blkdone_dval,
   output logic                   alldone_dval
);

   typedef enum logic {IDLE, RUN} state_e;

   state_e                 state_q, state_d;
   logic [DIM-1:0][BW-1:0] bofs_q, bofs_d;
   logic [DIM-1:0][BW-1:0] beg_q, beg_d;
   logic [DIM-1:0][BW-1:0] end_q, end_d;
   logic                   islast_q, islast_d;
`ifdef ACCUM_WALKER_STRIDE_EN
   logic [DIM-1:0][BW-1:0] step_q, step_d;
`endif

   logic accept, empty, adv, wrap_all;

   always_comb begin
      empty = 1'b0;
      for (int unsigned d = 0; d < DIM; d++) begin
         if (i_aofs_beg[d] >= i_aofs_end[d]) empty = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      bofs_d       = bofs_q;
      beg_d        = beg_q;
      end_d        = end_q;
      islast_d     = islast_q;
      accept       = 1'b0;
      adv          = 1'b0;
      src_ack      = 1'b0;
      dst_rdy      = 1'b0;
      o_lastpt     = 1'b0;
      blkdone_dval = 1'b0;
      alldone_dval = 1'b0;
`ifdef ACCUM_WALKER_STRIDE_EN
      step_d       = step_q;
`endif
      case (state_q)
         IDLE: begin
            accept  = src_rdy;
            src_ack = src_rdy;
            if (accept) begin
               bofs_d   = i_bofs;
               beg_d    = i_aofs_beg;
               end_d    = i_aofs_end;
               islast_d = i_islast;
`ifdef ACCUM_WALKER_STRIDE_EN
               for (int unsigned d = 0; d < DIM; d++) begin
                  step_d[d] = (i_astep[d] == '0) ? {{(BW-1){1'b0}}, 1'b1} : i_astep[d];
               end
`endif
               // Empty windows complete in the accept cycle and never enter RUN
               if (empty) begin
                  blkdone_dval = 1'b1;
                  alldone_dval = i_islast;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            dst_rdy  = 1'b1;
            o_lastpt = wrap_all;
            adv      = dst_ack;
            if (dst_ack && wrap_all) begin
               blkdone_dval = 1'b1;
               alldone_dval = islast_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         bofs_q   <= '0;
         beg_q    <= '0;
         end_q    <= '0;
         islast_q <= 1'b0;
`ifdef ACCUM_WALKER_STRIDE_EN
         step_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         bofs_q   <= bofs_d;
         beg_q    <= beg_d;
         end_q    <= end_d;
         islast_q <= islast_d;
`ifdef ACCUM_WALKER_STRIDE_EN
         step_q   <= step_d;
`endif
      end
   end

   nd_window_counter #(
      .BW  (BW),
      .DIM (DIM)
   ) u_counter (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (accept),
      .i_load_val (i_aofs_beg),
      .i_adv      (adv),
      .i_beg      (beg_q),
      .i_end      (end_q),
`ifdef ACCUM_WALKER_STRIDE_EN
      .i_step     (step_q),
`endif
      .o_coord    (o_aofs),
      .o_wrap_all (wrap_all)
   );

   always_comb begin
      o_bofs = bofs_q;
      for (int unsigned d = 0; d < DIM; d++) begin
         o_pos[d] = bofs_q[d] + o_aofs[d];
      end
   end

endmodule
